host_switch_ctrl: RTL and testbench

Host-selection controller sitting directly downstream of the command-frame decoder. It consumes that block's force_swi/com_swi/reset_A/reset_B/power_on_A/power_on_B outputs, watches heartbeat toggles from CPU A and CPU B, and decides which CPU is host. Its switch output feeds back into the command decoder as its `switch` input and drives the board's UART/bus routing.

---
 rtl/host_switch_ctrl_if.sv | 25 ++
 rtl/host_switch_ctrl.sv | 76 +++++++
 tb/tb_host_switch_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/host_switch_ctrl_if.sv
// host_switch_ctrl_if: heartbeat, command and host-selection signals between the decoder/board and host_switch_ctrl
interface host_switch_ctrl_if;
  logic       hb_a;
  logic       hb_b;
  logic       force_swi;
  logic       com_swi;
  logic       reset_A;
  logic       reset_B;
  logic       power_on_A;
  logic       power_on_B;
  logic       switch;
  logic       alive_a;
  logic       alive_b;
  logic       swi_event;
  logic [7:0] fail_cnt;
  logic       hold;
  modport master (
    output hb_a, hb_b, force_swi, com_swi, reset_A, reset_B, power_on_A, power_on_B,
    input  switch, alive_a, alive_b, swi_event, fail_cnt, hold
  );
  modport slave (
    input  hb_a, hb_b, force_swi, com_swi, reset_A, reset_B, power_on_A, power_on_B,
    output switch, alive_a, alive_b, swi_event, fail_cnt, hold
  );
endinterface

// File: rtl/host_switch_ctrl.sv
// host_switch_ctrl: picks CPU A or B as host from heartbeat health, forced commands and a post-switch holdoff
module host_switch_ctrl #(
  parameter logic [31:0] HB_TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] HOLDOFF    = 32'd1_000_000,
  parameter int          CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  host_switch_ctrl_if.slave bus
);
  // state encoding is {hold, switch} so both outputs come straight off the state flops
  typedef enum logic [1:0] {HOST_A = 2'b00, HOST_B = 2'b01, HOLD_A = 2'b10, HOLD_B = 2'b11} state_t;
  localparam logic [CNT_W-1:0] C_TO = CNT_W'(HB_TIMEOUT);
  localparam logic [CNT_W-1:0] C_HL = CNT_W'(HOLDOFF - 32'd1);
  logic [1:0]       r_s1, r_s2, r_s3, r_alive;
  logic [CNT_W-1:0] r_wd [2];
  logic [1:0]       w_hb, w_edge, w_pwr, w_rrst;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_hcnt, w_hcnt;
  logic [7:0]       r_fail;
  logic             r_evt, w_fo, w_cur_alive, w_oth_alive;
  assign w_hb   = {bus.hb_b, bus.hb_a};
  assign w_pwr  = {bus.power_on_B, bus.power_on_A};
  assign w_rrst = {bus.reset_B, bus.reset_A};
  assign w_edge = r_s2 ^ r_s3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_alive <= '0;
      r_wd    <= '{default: '0};
    end else begin
      r_s1 <= w_hb;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      for (int i = 0; i < 2; i++) begin
        r_wd[i]    <= w_edge[i] ? '0 : (r_wd[i] < C_TO) ? r_wd[i] + 1'b1 : r_wd[i];
        r_alive[i] <= (r_wd[i] < C_TO) & w_pwr[i] & ~w_rrst[i];
      end
    end
  assign w_cur_alive = r_alive[r_state[0]];
  assign w_oth_alive = r_alive[~r_state[0]];
  always_comb begin
    w_next = r_state;
    w_hcnt = '0;
    w_fo   = 1'b0;
    if (bus.force_swi)
      w_next = state_t'({1'b1, bus.com_swi});
    else if (r_state[1]) begin
      w_hcnt = (r_hcnt == C_HL) ? '0 : r_hcnt + 1'b1;
      w_next = (r_hcnt == C_HL) ? state_t'({1'b0, r_state[0]}) : r_state;
    end else if (!w_cur_alive && w_oth_alive) begin
      w_next = state_t'({1'b1, ~r_state[0]});
      w_fo   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= HOST_A;
      r_hcnt  <= '0;
      r_fail  <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hcnt  <= w_hcnt;
      r_evt   <= w_next[0] ^ r_state[0];
      r_fail  <= (w_fo && r_fail != 8'hFF) ? r_fail + 8'd1 : r_fail;
    end
  assign bus.switch    = r_state[0];
  assign bus.hold      = r_state[1];
  assign bus.swi_event = r_evt;
  assign bus.fail_cnt  = r_fail;
  assign bus.alive_a   = r_alive[0];
  assign bus.alive_b   = r_alive[1];
endmodule

// File: tb/tb_host_switch_ctrl.sv
// tb_host_switch_ctrl: directed scenarios for host selection, failover, forcing, saturation and async reset
module tb_host_switch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1, en_b = 1'b1;
  int   checks = 0, failures = 0, ev_cnt = 0;
  host_switch_ctrl_if bus();
  host_switch_ctrl #(.HB_TIMEOUT(32'd5000), .HOLDOFF(32'd200), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  // heartbeats toggle every 1000 clk while enabled
  initial begin
    bus.hb_a = 1'b0;
    bus.hb_b = 1'b0;
    forever begin
      repeat (1000) @(negedge clk);
      if (en_a) bus.hb_a = ~bus.hb_a;
      if (en_b) bus.hb_b = ~bus.hb_b;
    end
  end
  always @(negedge clk) if (bus.swi_event === 1'b1) ev_cnt++;
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({bus.switch, bus.alive_a, bus.alive_b, bus.swi_event, bus.hold, bus.fail_cnt} !== 13'h0) begin
      failures++;
      $display("FAIL reset_values got=%b exp=0", {bus.switch, bus.alive_a, bus.alive_b, bus.swi_event, bus.hold, bus.fail_cnt});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.switch, bus.alive_a, bus.alive_b, bus.hold} !== 4'b0110) begin
      failures++;
      $display("FAIL alive_after_release got=%b exp=0110", {bus.switch, bus.alive_a, bus.alive_b, bus.hold});
    end
  endtask
  task automatic test_steady();
    repeat (8000) step();
    checks++;
    if ({bus.switch, bus.alive_a, bus.alive_b, bus.hold, bus.fail_cnt} !== 12'b0110_0000_0000) begin
      failures++;
      $display("FAIL steady_state got=%b exp=011000000000", {bus.switch, bus.alive_a, bus.alive_b, bus.hold, bus.fail_cnt});
    end
    checks++;
    if (ev_cnt !== 0) begin
      failures++;
      $display("FAIL steady_no_event got=%0d exp=0", ev_cnt);
    end
  endtask
  task automatic test_failover();
    int n = 0;
    en_a = 1'b0;
    for (int k = 0; k < 8000 && bus.alive_a; k++) step();
    checks++;
    if (bus.alive_a !== 1'b0 || bus.switch !== 1'b0) begin
      failures++;
      $display("FAIL alive_a_fall got alive=%b switch=%b exp alive=0 switch=0", bus.alive_a, bus.switch);
    end
    step();
    checks++;
    if ({bus.switch, bus.swi_event, bus.hold, bus.fail_cnt} !== {3'b111, 8'd1}) begin
      failures++;
      $display("FAIL auto_failover got=%b exp=11100000001", {bus.switch, bus.swi_event, bus.hold, bus.fail_cnt});
    end
    while (bus.hold && n < 1000) begin step(); n++; end
    checks++;
    if (n !== 200 || ev_cnt !== 1) begin
      failures++;
      $display("FAIL failover_hold_len got=%0d events=%0d exp=200 events=1", n, ev_cnt);
    end
  endtask
  task automatic test_force_back();
    int n = 0, bad = 0;
    bus.com_swi = 1'b0;
    bus.force_swi = 1'b1;
    step();
    bus.force_swi = 1'b0;
    checks++;
    if ({bus.switch, bus.swi_event, bus.hold, bus.fail_cnt} !== {3'b011, 8'd1}) begin
      failures++;
      $display("FAIL force_to_a got=%b exp=01100000001", {bus.switch, bus.swi_event, bus.hold, bus.fail_cnt});
    end
    while (bus.hold && n < 1000) begin
      if (bus.switch !== 1'b0) bad++;
      step();
      n++;
    end
    checks++;
    if (n !== 200 || bad !== 0 || bus.switch !== 1'b0) begin
      failures++;
      $display("FAIL hold_blocks_auto got len=%0d bad=%0d switch=%b exp len=200 bad=0 switch=0", n, bad, bus.switch);
    end
    step();
    checks++;
    if ({bus.switch, bus.hold, bus.fail_cnt} !== {2'b11, 8'd2}) begin
      failures++;
      $display("FAIL auto_after_hold got=%b exp=1100000010", {bus.switch, bus.hold, bus.fail_cnt});
    end
  endtask
  task automatic test_force_same_cycle();
    en_a = 1'b1;
    for (int k = 0; k < 3000 && !bus.alive_a; k++) step();
    for (int k = 0; k < 300 && bus.hold; k++) step();
    bus.com_swi = 1'b0;
    bus.force_swi = 1'b1;
    step();
    bus.force_swi = 1'b0;
    for (int k = 0; k < 300 && bus.hold; k++) step();
    checks++;
    if ({bus.switch, bus.hold, bus.alive_a, bus.alive_b} !== 4'b0011) begin
      failures++;
      $display("FAIL back_on_a got=%b exp=0011", {bus.switch, bus.hold, bus.alive_a, bus.alive_b});
    end
    bus.reset_A = 1'b1;
    step();
    checks++;
    if (bus.alive_a !== 1'b0 || bus.switch !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_kills got alive=%b switch=%b exp alive=0 switch=0", bus.alive_a, bus.switch);
    end
    bus.force_swi = 1'b1;
    step();
    bus.force_swi = 1'b0;
    bus.reset_A = 1'b0;
    checks++;
    if ({bus.switch, bus.swi_event, bus.hold, bus.fail_cnt} !== {3'b001, 8'd2}) begin
      failures++;
      $display("FAIL force_beats_auto got=%b exp=00100000010", {bus.switch, bus.swi_event, bus.hold, bus.fail_cnt});
    end
    for (int k = 0; k < 300 && bus.hold; k++) step();
    step();
    checks++;
    if ({bus.switch, bus.hold, bus.alive_a} !== 3'b001) begin
      failures++;
      $display("FAIL stay_on_a got=%b exp=001", {bus.switch, bus.hold, bus.alive_a});
    end
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      if (bus.switch) bus.reset_B = 1'b1;
      else bus.reset_A = 1'b1;
      step();
      bus.reset_A = 1'b0;
      bus.reset_B = 1'b0;
      repeat (205) step();
    end
    checks++;
    if (bus.fail_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL fail_cnt_saturate got=%0h exp=ff", bus.fail_cnt);
    end
    checks++;
    if ({bus.switch, bus.hold} !== 2'b00) begin
      failures++;
      $display("FAIL toggle_parity got=%b exp=00", {bus.switch, bus.hold});
    end
  endtask
  task automatic test_reset_mid_hold();
    bus.reset_A = 1'b1;
    step();
    bus.reset_A = 1'b0;
    repeat (11) step();
    checks++;
    if ({bus.switch, bus.hold} !== 2'b11) begin
      failures++;
      $display("FAIL in_hold_b got=%b exp=11", {bus.switch, bus.hold});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.switch, bus.alive_a, bus.alive_b, bus.swi_event, bus.hold, bus.fail_cnt} !== 13'h0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0", {bus.switch, bus.alive_a, bus.alive_b, bus.swi_event, bus.hold, bus.fail_cnt});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.switch, bus.hold, bus.alive_a, bus.alive_b, bus.fail_cnt} !== {4'b0011, 8'd0}) begin
      failures++;
      $display("FAIL after_reset got=%b exp=001100000000", {bus.switch, bus.hold, bus.alive_a, bus.alive_b, bus.fail_cnt});
    end
  endtask
  initial begin
    bus.force_swi  = 1'b0;
    bus.com_swi    = 1'b0;
    bus.reset_A    = 1'b0;
    bus.reset_B    = 1'b0;
    bus.power_on_A = 1'b1;
    bus.power_on_B = 1'b1;
    test_reset();
    test_steady();
    test_failover();
    test_force_back();
    test_force_same_cycle();
    test_saturate();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
